rf_write_arbiter: RTL and testbench

Arbitrates two writeback sources onto the register file's single write port. Source A is ALU writeback; source B is memory-load writeback. The block registers the winning request and drives the write port, whose register index feeds the 4-to-16 write decoder. It also publishes a one-hot busy mask of the in-flight write so that hazard logic can stall readers.

---
 rtl/rf_write_arbiter_if.sv | 30 +++
 rtl/rf_write_arbiter.sv | 100 ++++++++++
 tb/tb_rf_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the two sources (A = ALU, B = load) and the register
// file write port, including the busy mask used by hazard logic.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 16
);
   logic              a_valid;
   logic [3:0]        a_reg;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [3:0]        b_reg;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              wr_en;
   logic [3:0]        wr_reg;
   logic [DATA_W-1:0] wr_data;
   logic [15:0]       busy_mask;

   // Sources and register-file side.
   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      input  a_ready, b_ready, wr_en, wr_reg, wr_data, busy_mask
   );

   // Arbiter side.
   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      output a_ready, b_ready, wr_en, wr_reg, wr_data, busy_mask
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter onto the single register-file write port.
// Round-robin or B-priority with an A starvation guard; registered write
// port with R0 writes suppressed and a one-hot busy mask of the live write.
module rf_write_arbiter #(
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prio_b,
   input  logic               hold,
   output logic [3:0]         a_wait,
   rf_write_arbiter_if.slave  bus
);
   typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;

   grant_t            last_grant_reg, last_grant_next;
   logic [3:0]        a_wait_reg, a_wait_next;
   logic              wr_en_reg, wr_en_next;
   logic [3:0]        wr_idx_reg, wr_idx_next;
   logic [DATA_W-1:0] wr_data_reg, wr_data_next;
   logic              a_win, b_win;
   logic              go, a_xfer, b_xfer;

   // Pick a winner from the valids alone; hold and reset gate it afterwards.
   always_comb begin
      a_win = 1'b0;
      b_win = 1'b0;
      if (bus.a_valid && bus.b_valid) begin
         if (prio_b)
            a_win = (a_wait_reg == 4'(MAX_WAIT));
         else
            a_win = (last_grant_reg == GRANT_B);
         b_win = !a_win;
      end else begin
         a_win = bus.a_valid;
         b_win = bus.b_valid;
      end
   end

   assign go          = rst_n && !hold;
   assign a_xfer      = go && a_win;
   assign b_xfer      = go && b_win;
   assign bus.a_ready = a_xfer;
   assign bus.b_ready = b_xfer;

   // Next values for the grant history, starvation counter and write port.
   always_comb begin
      last_grant_next = last_grant_reg;
      a_wait_next     = a_wait_reg;
      wr_en_next      = 1'b0;
      wr_idx_next     = wr_idx_reg;
      wr_data_next    = wr_data_reg;
      if (a_xfer) begin
         last_grant_next = GRANT_A;
         wr_en_next      = (bus.a_reg != 4'd0);
         wr_idx_next     = bus.a_reg;
         wr_data_next    = bus.a_data;
      end else if (b_xfer) begin
         last_grant_next = GRANT_B;
         wr_en_next      = (bus.b_reg != 4'd0);
         wr_idx_next     = bus.b_reg;
         wr_data_next    = bus.b_data;
      end
      // Counts waiting cycles, hold cycles included; saturates at 15.
      if (!bus.a_valid || a_xfer)
         a_wait_next = 4'd0;
      else if (a_wait_reg != 4'hF)
         a_wait_next = a_wait_reg + 4'd1;
   end

   // State and output registers; reset drops any pending write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_reg <= GRANT_B;
         a_wait_reg     <= 4'd0;
         wr_en_reg      <= 1'b0;
         wr_idx_reg     <= 4'd0;
         wr_data_reg    <= '0;
      end else begin
         last_grant_reg <= last_grant_next;
         a_wait_reg     <= a_wait_next;
         wr_en_reg      <= wr_en_next;
         wr_idx_reg     <= wr_idx_next;
         wr_data_reg    <= wr_data_next;
      end
   end

   assign bus.wr_en   = wr_en_reg;
   assign bus.wr_reg  = wr_idx_reg;
   assign bus.wr_data = wr_data_reg;
   assign a_wait      = a_wait_reg;

   // Busy mask: one-hot decode of the register being written this cycle.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_busy
         assign bus.busy_mask[gi] = wr_en_reg && (wr_idx_reg == 4'(gi));
      end
   endgenerate
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run, all
// compared against a cycle-level reference model kept here.
module tb_rf_write_arbiter;
   localparam int DATA_W   = 16;
   localparam int MAX_WAIT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       prio_b = 1'b0;
   logic       hold = 1'b0;
   logic [3:0] a_wait;

   rf_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

   rf_write_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .prio_b (prio_b),
      .hold   (hold),
      .a_wait (a_wait),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: who won last, how long A has waited, and what
   // the write port should show after the coming edge.
   bit m_last_b  = 1'b1;
   int m_wait    = 0;
   bit m_wr_en   = 1'b0;
   int m_wr_reg  = 0;
   int m_wr_data = 0;

   // 0 = nobody, 1 = A, 2 = B for the inputs currently applied.
   function automatic int predict();
      if (!rst_n || hold) return 0;
      if (!bus.a_valid && !bus.b_valid) return 0;
      if (bus.a_valid && !bus.b_valid) return 1;
      if (bus.b_valid && !bus.a_valid) return 2;
      if (prio_b) return (m_wait == MAX_WAIT) ? 1 : 2;
      return m_last_b ? 1 : 2;
   endfunction

   function automatic logic [15:0] exp_busy();
      logic [15:0] one;
      one = 16'h0001;
      return m_wr_en ? (one << m_wr_reg) : 16'h0000;
   endfunction

   // Advance the model by one clock, then move to just after the edge.
   task automatic tick();
      int w;
      w = predict();
      if (!rst_n) begin
         m_last_b = 1'b1; m_wait = 0;
         m_wr_en = 1'b0; m_wr_reg = 0; m_wr_data = 0;
      end else begin
         if (w == 1) begin
            m_wr_en = (bus.a_reg != 0); m_wr_reg = int'(bus.a_reg);
            m_wr_data = int'(bus.a_data); m_last_b = 1'b0;
         end else if (w == 2) begin
            m_wr_en = (bus.b_reg != 0); m_wr_reg = int'(bus.b_reg);
            m_wr_data = int'(bus.b_data); m_last_b = 1'b1;
         end else begin
            m_wr_en = 1'b0;
         end
         if (!bus.a_valid || w == 1) m_wait = 0;
         else if (m_wait < 15) m_wait = m_wait + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit av, input int ar, input int ad,
                        input bit bv, input int br, input int bd);
      bus.a_valid = av; bus.a_reg = 4'(ar); bus.a_data = 16'(ad);
      bus.b_valid = bv; bus.b_reg = 4'(br); bus.b_data = 16'(bd);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hold = 1'b0;
      drive(1, 3, 16'h1234, 1, 5, 16'h5678);
      #1;
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got a=%b b=%b expected 0 0", bus.a_ready, bus.b_ready);
      end
      tick();
      checks++;
      if (bus.wr_en !== 1'b0 || bus.wr_reg !== 4'd0 || bus.wr_data !== 16'd0 ||
          bus.busy_mask !== 16'd0 || a_wait !== 4'd0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b reg=%0d data=%h busy=%h wait=%0d expected all 0",
                  bus.wr_en, bus.wr_reg, bus.wr_data, bus.busy_mask, a_wait);
      end
      $display("reset: outputs en=%b busy=%h wait=%0d", bus.wr_en, bus.busy_mask, a_wait);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_round_robin_tie();
      prio_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) drive(1, 3, 16'h1111, 1, 5, 16'h2222);
         else drive(0, 0, 0, 0, 0, 0);
         #1;
         if (k < 4) begin
            checks++;
            if (bus.a_ready !== (k % 2 == 0) || bus.b_ready !== (k % 2 == 1)) begin
               errors++;
               $display("FAIL rr_grant%0d: got a=%b b=%b expected a=%b b=%b",
                        k, bus.a_ready, bus.b_ready, k % 2 == 0, k % 2 == 1);
            end
         end
         if (k > 0) begin
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_reg !== ((k % 2 == 1) ? 4'd3 : 4'd5) ||
                bus.busy_mask !== ((k % 2 == 1) ? 16'h0008 : 16'h0020)) begin
               errors++;
               $display("FAIL rr_write%0d: got en=%b reg=%0d busy=%h expected en=1 reg=%0d",
                        k, bus.wr_en, bus.wr_reg, bus.busy_mask, (k % 2 == 1) ? 3 : 5);
            end
            $display("rr: cycle %0d wr_reg=%0d busy=%h", k, bus.wr_reg, bus.busy_mask);
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      prio_b = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1, 1, 16'hA000 + k, 1, 2, 16'hB000 + k);
         #1;
         checks++;
         if (bus.a_ready !== (k % 5 == 4) || bus.b_ready !== (k % 5 != 4) ||
             a_wait !== 4'(k % 5)) begin
            errors++;
            $display("FAIL starve%0d: got a=%b b=%b wait=%0d expected a=%b wait=%0d",
                     k, bus.a_ready, bus.b_ready, a_wait, k % 5 == 4, k % 5);
         end
         $display("starve: cycle %0d a_ready=%b a_wait=%0d", k, bus.a_ready, a_wait);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_r0_drop();
      prio_b = 1'b0;
      drive(1, 0, 16'hFFFF, 0, 0, 0);
      #1;
      checks++;
      if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
         errors++;
         $display("FAIL r0_ready: got a=%b b=%b expected a=1 b=0", bus.a_ready, bus.b_ready);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (bus.wr_en !== 1'b0 || bus.busy_mask !== 16'd0 || a_wait !== 4'd0) begin
         errors++;
         $display("FAIL r0_write: got en=%b busy=%h wait=%0d expected 0 0 0",
                  bus.wr_en, bus.busy_mask, a_wait);
      end
      $display("r0: wr_en=%b busy=%h", bus.wr_en, bus.busy_mask);
   endtask

   task automatic test_hold();
      prio_b = 1'b0;
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1, 4, 16'h4444, 1, 6, 16'h6666);
         #1;
         checks++;
         if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.wr_en !== 1'b0 ||
             a_wait !== 4'(k)) begin
            errors++;
            $display("FAIL hold%0d: got a=%b b=%b en=%b wait=%0d expected 0 0 0 %0d",
                     k, bus.a_ready, bus.b_ready, bus.wr_en, a_wait, k);
         end
         tick();
      end
      hold = 1'b0;
      #1;
      // Last grant was A (the R0 transfer), so B wins the tie.
      checks++;
      if (a_wait !== 4'd3 || bus.wr_en !== 1'b0 || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got wait=%0d en=%b a=%b b=%b expected 3 0 0 1",
                  a_wait, bus.wr_en, bus.a_ready, bus.b_ready);
      end
      tick();
      checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_reg !== 4'd6 || bus.wr_data !== 16'h6666) begin
         errors++;
         $display("FAIL hold_write: got en=%b reg=%0d data=%h expected 1 6 6666",
                  bus.wr_en, bus.wr_reg, bus.wr_data);
      end
      $display("hold: released, wr_reg=%0d a_wait=%0d", bus.wr_reg, a_wait);
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 0, 1, 7, 16'hABCD);
      #1;
      checks++;
      if (bus.b_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_ready: got b=%b expected 1", bus.b_ready);
      end
      tick();
      rst_n = 1'b0;
      drive(1, 2, 16'h0202, 1, 7, 16'hABCD);
      #1;
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.wr_en !== 1'b1 ||
          bus.wr_reg !== 4'd7 || bus.wr_data !== 16'hABCD) begin
         errors++;
         $display("FAIL rstmid_pending: got a=%b b=%b en=%b reg=%0d data=%h expected 0 0 1 7 abcd",
                  bus.a_ready, bus.b_ready, bus.wr_en, bus.wr_reg, bus.wr_data);
      end
      tick();
      checks++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.wr_en !== 1'b0 ||
          bus.wr_reg !== 4'd0 || bus.wr_data !== 16'd0 || bus.busy_mask !== 16'd0 ||
          a_wait !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_cleared: got a=%b b=%b en=%b reg=%0d data=%h busy=%h wait=%0d expected all 0",
                  bus.a_ready, bus.b_ready, bus.wr_en, bus.wr_reg, bus.wr_data, bus.busy_mask, a_wait);
      end
      $display("reset_mid: wr_en=%b wr_reg=%0d", bus.wr_en, bus.wr_reg);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_single_source();
      int writes;
      int d;
      writes = 0;
      for (int i = 0; i <= 16; i++) begin
         d = int'($urandom_range(0, 16'hFFFF));
         if (i < 16) drive(1, i, d, 0, 0, 0);
         else drive(0, 0, 0, 0, 0, 0);
         #1;
         if (i < 16) begin
            checks++;
            if (bus.a_ready !== 1'b1) begin
               errors++;
               $display("FAIL single_ready%0d: got %b expected 1", i, bus.a_ready);
            end
         end
         checks++;
         if (bus.wr_en !== (i >= 2) || (i >= 2 && (bus.wr_reg !== 4'(i - 1) ||
             bus.wr_data !== 16'(m_wr_data)))) begin
            errors++;
            $display("FAIL single_write%0d: got en=%b reg=%0d data=%h expected en=%b reg=%0d data=%h",
                     i, bus.wr_en, bus.wr_reg, bus.wr_data, i >= 2, i - 1, m_wr_data);
         end
         if (bus.wr_en === 1'b1) writes++;
         tick();
      end
      checks++;
      if (writes != 15) begin
         errors++;
         $display("FAIL single_count: got %0d writes expected 15", writes);
      end
      $display("single: %0d writes observed", writes);
   endtask

   task automatic test_random();
      int w;
      for (int n = 0; n < 400; n++) begin
         rst_n  = ($urandom_range(0, 29) != 0);
         hold   = ($urandom_range(0, 7) == 0);
         prio_b = $urandom_range(0, 1);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 16'hFFFF),
               $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 16'hFFFF));
         #1;
         w = predict();
         checks++;
         if (bus.a_ready !== (w == 1) || bus.b_ready !== (w == 2) ||
             bus.wr_en !== m_wr_en || a_wait !== 4'(m_wait) ||
             bus.busy_mask !== exp_busy() ||
             (m_wr_en && (bus.wr_reg !== 4'(m_wr_reg) || bus.wr_data !== 16'(m_wr_data)))) begin
            errors++;
            $display("FAIL random%0d: got a=%b b=%b en=%b reg=%0d data=%h busy=%h wait=%0d expected a=%b b=%b en=%b reg=%0d data=%h busy=%h wait=%0d",
                     n, bus.a_ready, bus.b_ready, bus.wr_en, bus.wr_reg, bus.wr_data, bus.busy_mask, a_wait,
                     w == 1, w == 2, m_wr_en, m_wr_reg, m_wr_data, exp_busy(), m_wait);
         end
         tick();
      end
      $display("random: 400 cycles compared");
      rst_n = 1'b1; hold = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin_tie();
      test_starvation();
      test_r0_drop();
      test_hold();
      test_reset_mid();
      test_single_source();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
